uart_rx_buffered: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_fifo.sv | 58 +++++
 rtl/uart_rx_buffered.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART receiver.
// The PARITY state is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

  // Receiver deframing states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  localparam int OSR       = 16;  // oversample ticks per bit
  localparam int MID_TICK  = 7;   // tick index at the middle of the start bit
  localparam int DATA_BITS = 8;

  // Error flags raised at the stop-sample tick
  typedef struct packed {
    logic frame;
    logic overrun;
    logic parity;
  } rx_err_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO with occupancy count for the UART receiver.
// A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Byte storage, not reset: contents are only visible through a valid pointer
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Show-ahead read; forced to zero when empty so the port is clean after reset
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with 16x oversampling, 8N1 deframing and a show-ahead byte FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing and the parity_err output.
module uart_rx_buffered #(
  parameter int DEPTH = 8,
  parameter int OSR   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               tick_div,
  input  logic                     rx,
  input  logic                     rd_ready,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     frame_err,
  output logic                     overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                     parity_err
`endif
);
  import uart_pkg::*;

  localparam logic [3:0] LAST_TICK = 4'(OSR - 1);
  localparam logic [3:0] MID_TCK   = 4'(MID_TICK);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  rx_state_t  state;
  rx_state_t  state_next;
  logic       rx_meta;
  logic       rx_s;
  logic       rx_s_d;
  logic       rx_fall;
  logic [3:0] tick_cnt;
  logic [3:0] div_m1;
  logic       tick;
  logic [3:0] os_cnt;
  logic [2:0] bit_idx;
  logic [7:0] data_sr;
  logic       sample_data;
  logic       stop_tick;
  logic       push_req;
  logic       fifo_full;
  logic       fifo_empty;

`ifdef UART_RX_PARITY_EN
  logic       sample_par;
  logic       par_bit;

  // Even parity holds when data plus parity bit carry an even number of ones
  function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
    return ~(^{d, p});
  endfunction
`endif

  assign rx_fall = rx_s_d & ~rx_s;

  // Divider of 0 or 1 both give a tick every clk; >= lets a shrunken divider wrap
  assign div_m1 = (tick_div > 4'd1) ? (tick_div - 4'd1) : 4'd0;
  assign tick   = (tick_cnt >= div_m1);

  // Control registers: synchroniser, tick generator, FSM state, counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_s_d   <= 1'b1;
      tick_cnt <= '0;
      state    <= IDLE;
      os_cnt   <= '0;
      bit_idx  <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
      // Start edge realigns the oversample grid to the start bit
      if (state == IDLE && rx_fall) tick_cnt <= '0;
      else if (tick)                tick_cnt <= '0;
      else                          tick_cnt <= tick_cnt + 4'd1;
      state <= state_next;
      if (state_next != state) os_cnt <= '0;
      else if (tick)           os_cnt <= os_cnt + 4'd1;
      if (state != DATA)    bit_idx <= '0;
      else if (sample_data) bit_idx <= bit_idx + 3'd1;
    end
  end

  // Received bits, LSB first; not reset since a reset frame is never pushed
  always_ff @(posedge clk) begin
    if (sample_data) data_sr <= {rx_s, data_sr[7:1]};
`ifdef UART_RX_PARITY_EN
    if (sample_par)  par_bit <= rx_s;
`endif
  end

  // Next-state and sample strobes for the deframing FSM
  always_comb begin
    state_next  = state;
    sample_data = 1'b0;
    stop_tick   = 1'b0;
`ifdef UART_RX_PARITY_EN
    sample_par  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_fall) state_next = START;
      end
      START: begin
        // Mid start bit: a line already back high was a glitch
        if (tick && os_cnt == MID_TCK) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tick && os_cnt == LAST_TICK) begin
          sample_data = 1'b1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && os_cnt == LAST_TICK) begin
          sample_par = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && os_cnt == LAST_TICK) begin
          stop_tick  = 1'b1;
          state_next = rx_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // A held-low break must return high before a new start is accepted
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign frame_err = stop_tick & ~rx_s;
`ifdef UART_RX_PARITY_EN
  assign parity_err = stop_tick & rx_s & ~even_parity_ok(data_sr, par_bit);
  assign push_req   = stop_tick & rx_s & even_parity_ok(data_sr, par_bit);
`else
  assign push_req   = stop_tick & rx_s;
`endif

  // Dropped only when full and the host is not freeing a slot this cycle
  assign overrun  = push_req & fifo_full & ~(rd_ready & ~fifo_empty);
  assign rd_valid = ~fifo_empty;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_req),
    .wr_data (data_sr),
    .pop     (rd_ready),
    .rd_data (rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: serial frames driven bit by bit, checked against a
// byte-queue model of the FIFO plus expected error-pulse counts.
module tb_uart_rx_buffered;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    tick_div;
  logic          rx;
  logic          rd_ready;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] fifo_count;
  logic          frame_err;
  logic          overrun;
`ifdef UART_RX_PARITY_EN
  logic          parity_err;
`endif

  int n_vec   = 0;
  int n_err   = 0;
  int fe_cnt  = 0;
  int ovr_cnt = 0;
  int exp_fe  = 0;
  int exp_ovr = 0;
  logic [7:0] model_q[$];

  uart_rx_buffered #(.DEPTH(DEPTH), .OSR(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_div   (tick_div),
    .rx         (rx),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Count error pulses away from the active edge
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1)   ovr_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int bit_clks();
    return 16 * ((tick_div < 4'd2) ? 1 : int'(tick_div));
  endfunction

  // Model of one received good frame with the host not reading
  task automatic model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else exp_ovr++;
  endtask

  // Start bit, 8 data bits LSB first, stop bit; rx is left at the stop level
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    int bt;
    bt = bit_clks();
    rx = 1'b0;
    cyc(bt);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(bt);
    end
    rx = stop_bit;
    cyc(bt);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rd_ready = 1'b0; tick_div = 4'd12;
    cyc(3);
    n_vec++;
    if (rd_valid !== 1'b0 || fifo_count !== '0 || rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_fifo: valid=%0b count=%0d data=%02h required 0/0/00", rd_valid, fifo_count, rd_data);
    end
    n_vec++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_err: frame_err=%0b overrun=%0b required 0/0", frame_err, overrun);
    end
    rst = 1'b0;
    cyc(5);
  endtask

  task automatic test_single();
    tick_div = 4'd12;
    send_frame(8'hCB, 1'b1);
    model_push(8'hCB);
    cyc(4);
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hCB || fifo_count !== CW'(1)) begin
      n_err++;
      $display("FAIL single_rx: valid=%0b data=%02h count=%0d required 1/cb/1", rd_valid, rd_data, fifo_count);
    end
    n_vec++;
    if (fe_cnt !== exp_fe || ovr_cnt !== exp_ovr) begin
      n_err++;
      $display("FAIL single_err: fe=%0d ovr=%0d required %0d/%0d", fe_cnt, ovr_cnt, exp_fe, exp_ovr);
    end
    rd_ready = 1'b1;
    while (model_q.size() > 0) begin
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
        n_err++;
        $display("FAIL single_drain: valid=%0b data=%02h required 1/%02h", rd_valid, rd_data, model_q[0]);
      end
      void'(model_q.pop_front());
      cyc(1);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    tick_div = 4'd12;
    send_frame(8'hCB, 1'b1);
    model_push(8'hCB);
    send_frame(8'h6F, 1'b1);
    model_push(8'h6F);
    cyc(4);
    n_vec++;
    if (fifo_count !== CW'(model_q.size())) begin
      n_err++;
      $display("FAIL b2b_count: count=%0d required %0d", fifo_count, model_q.size());
    end
    rd_ready = 1'b1;
    while (model_q.size() > 0) begin
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
        n_err++;
        $display("FAIL b2b_drain: valid=%0b data=%02h required 1/%02h", rd_valid, rd_data, model_q[0]);
      end
      void'(model_q.pop_front());
      cyc(1);
    end
    n_vec++;
    if (rd_valid !== 1'b0 || fifo_count !== '0) begin
      n_err++;
      $display("FAIL b2b_empty: valid=%0b count=%0d required 0/0", rd_valid, fifo_count);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_overrun();
    int ovr0;
    tick_div = 4'd1;
    ovr0 = ovr_cnt;
    for (int i = 0; i < 9; i++) begin
      send_frame(8'(i), 1'b1);
      model_push(8'(i));
      cyc(2);
      if (i == 7) begin
        n_vec++;
        if (ovr_cnt - ovr0 !== 0 || fifo_count !== CW'(DEPTH)) begin
          n_err++;
          $display("FAIL ovr_fill: ovr_pulses=%0d count=%0d required 0/%0d", ovr_cnt - ovr0, fifo_count, DEPTH);
        end
      end
    end
    n_vec++;
    if (ovr_cnt - ovr0 !== 1 || ovr_cnt !== exp_ovr) begin
      n_err++;
      $display("FAIL ovr_pulse: ovr_pulses=%0d total=%0d required 1/%0d", ovr_cnt - ovr0, ovr_cnt, exp_ovr);
    end
    n_vec++;
    if (fifo_count !== CW'(DEPTH) || rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL ovr_keep: count=%0d data=%02h required %0d/00", fifo_count, rd_data, DEPTH);
    end
    rd_ready = 1'b1;
    while (model_q.size() > 0) begin
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
        n_err++;
        $display("FAIL ovr_drain: valid=%0b data=%02h required 1/%02h", rd_valid, rd_data, model_q[0]);
      end
      void'(model_q.pop_front());
      cyc(1);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_frame_err();
    int fe0;
    tick_div = 4'd2;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    exp_fe++;
    cyc(3 * bit_clks());
    n_vec++;
    if (fe_cnt - fe0 !== 1 || fifo_count !== '0) begin
      n_err++;
      $display("FAIL ferr_pulse: fe_pulses=%0d count=%0d required 1/0", fe_cnt - fe0, fifo_count);
    end
    rx = 1'b1;
    cyc(2 * bit_clks());
    n_vec++;
    if (fe_cnt - fe0 !== 1 || fifo_count !== '0 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ferr_break: fe_pulses=%0d count=%0d valid=%0b required 1/0/0", fe_cnt - fe0, fifo_count, rd_valid);
    end
    send_frame(8'hA5, 1'b1);
    model_push(8'hA5);
    cyc(4);
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || fifo_count !== CW'(1)) begin
      n_err++;
      $display("FAIL ferr_next: valid=%0b data=%02h count=%0d required 1/a5/1", rd_valid, rd_data, fifo_count);
    end
    rd_ready = 1'b1;
    while (model_q.size() > 0) begin
      void'(model_q.pop_front());
      cyc(1);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_glitch();
    int fe0, ovr0;
    tick_div = 4'd12;
    fe0 = fe_cnt; ovr0 = ovr_cnt;
    rx = 1'b0;
    cyc(40);
    rx = 1'b1;
    cyc(2 * bit_clks());
    n_vec++;
    if (fifo_count !== '0 || fe_cnt !== fe0 || ovr_cnt !== ovr0) begin
      n_err++;
      $display("FAIL glitch: count=%0d fe_pulses=%0d ovr_pulses=%0d required 0/0/0", fifo_count, fe_cnt - fe0, ovr_cnt - ovr0);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    int bt;
    tick_div = 4'd12;
    bt = bit_clks();
    send_frame(8'h11, 1'b1);
    model_push(8'h11);
    cyc(4);
    b = 8'hCB;
    rx = 1'b0;
    cyc(bt);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      cyc(bt);
    end
    rx = b[3];
    cyc(bt / 2);
    rst = 1'b1;
    rx = 1'b1;
    model_q.delete();
    cyc(1);
    n_vec++;
    if (rd_valid !== 1'b0 || fifo_count !== '0 || rd_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_out: valid=%0b count=%0d data=%02h fe=%0b ovr=%0b required all 0", rd_valid, fifo_count, rd_data, frame_err, overrun);
    end
    cyc(1);
    rst = 1'b0;
    cyc(2 * bt);
    n_vec++;
    if (rd_valid !== 1'b0 || fifo_count !== '0) begin
      n_err++;
      $display("FAIL midrst_idle: valid=%0b count=%0d required 0/0", rd_valid, fifo_count);
    end
    send_frame(8'h3C, 1'b1);
    model_push(8'h3C);
    cyc(4);
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h3C || fifo_count !== CW'(1)) begin
      n_err++;
      $display("FAIL midrst_next: valid=%0b data=%02h count=%0d required 1/3c/1", rd_valid, rd_data, fifo_count);
    end
    rd_ready = 1'b1;
    while (model_q.size() > 0) begin
      void'(model_q.pop_front());
      cyc(1);
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       good;
    for (int k = 0; k < 14; k++) begin
      tick_div = 4'($urandom_range(0, 4));
      b        = 8'($urandom);
      good     = ($urandom_range(0, 5) != 0);
      send_frame(b, good);
      if (good) model_push(b);
      else exp_fe++;
      rx = 1'b1;
      cyc(4 + $urandom_range(0, 20));
      n_vec++;
      if (fifo_count !== CW'(model_q.size()) || fe_cnt !== exp_fe || ovr_cnt !== exp_ovr) begin
        n_err++;
        $display("FAIL rand_frame%0d: count=%0d fe=%0d ovr=%0d required %0d/%0d/%0d", k, fifo_count, fe_cnt, ovr_cnt, model_q.size(), exp_fe, exp_ovr);
      end
      if (model_q.size() > 0) begin
        n_vec++;
        if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
          n_err++;
          $display("FAIL rand_head%0d: valid=%0b data=%02h required 1/%02h", k, rd_valid, rd_data, model_q[0]);
        end
      end
      if ($urandom_range(0, 3) == 0 || k == 13) begin
        rd_ready = 1'b1;
        while (model_q.size() > 0) begin
          n_vec++;
          if (rd_valid !== 1'b1 || rd_data !== model_q[0]) begin
            n_err++;
            $display("FAIL rand_drain%0d: valid=%0b data=%02h required 1/%02h", k, rd_valid, rd_data, model_q[0]);
          end
          void'(model_q.pop_front());
          cyc(1);
        end
        rd_ready = 1'b0;
        n_vec++;
        if (rd_valid !== 1'b0 || fifo_count !== '0) begin
          n_err++;
          $display("FAIL rand_empty%0d: valid=%0b count=%0d required 0/0", k, rd_valid, fifo_count);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
